trig_ctrl: RTL and testbench
============================

Name: trig_ctrl

Overview:
- Owns the debug trigger CSR bank (tselect, tdata1/2/3 for two triggers) and sequences trigger hits into the core.
- Consumes per-trigger hit pulses from the trigger matcher, which it also configures from the CSR bank.
- Converts each accepted hit into either a debug-halt request or a breakpoint-exception request, holds that request until the core acks it, and records the hit bit and the cause PC.
- Sits between the CSR file, the trigger matcher and the debug/exception control logic.

Parameters:
DATA_WIDTH, 32, CSR data width
ADDR_WIDTH, 32, PC/address width
CSR_TSELECT, 12'h7A0, tselect CSR address
CSR_TDATA1, 12'h7A1, tdata1 CSR address (tdata2 = +1, tdata3 = +2)

Ports:
cpu_clk  in  1  cpu clock
cpu_rst  in  1  synchronous reset, active-high
csr_addr  in  12  CSR address
csr_wr_en  in  1  CSR write strobe, one cycle
csr_wr_data  in  DATA_WIDTH  CSR write data
csr_rd_data  out  DATA_WIDTH  combinational read of the addressed trigger CSR; 0 if the address is not a trigger CSR
dbg_mode  in  1  core is in debug mode
trig0_hit  in  1  matcher hit, trigger 0 (chain already resolved)
trig1_hit  in  1  matcher hit, trigger 1
hit_pc  in  ADDR_WIDTH  PC of the hitting instruction
tselect  out  1  selected trigger index
tdata1_t0, tdata1_t1  out  DATA_WIDTH  trigger configs to matcher
tdata2_t0, tdata2_t1  out  DATA_WIDTH  compare values
tdata3_t0, tdata3_t1  out  DATA_WIDTH  tdata3 storage
halt_req  out  1  request debug-mode entry
halt_ack  in  1  debug entry accepted
bkpt_exp_req  out  1  request breakpoint exception
bkpt_exp_ack  in  1  exception taken
cause_pc  out  ADDR_WIDTH  captured hit_pc, valid while a request is high
cause_trig  out  1  index of the fired trigger

Behaviour:
- tdata1 layout:
  - type[31:28] is fixed at 2 (read-only).
  - dmode[27].
  - maskmax[26:21] = 0 (read-only).
  - hit[20].
  - select[19] = 0 (read-only).
  - timing[18], sizelo[17:16], action[15:12], chain[11], match[10:7], m[6].
  - [5:3] = 0 (read-only).
  - execute[2], store[1], load[0].
- Reset values: tselect = 0; tdata1_tX = 32'h2000_0000; tdata2/3 = 0; halt_req = 0; bkpt_exp_req = 0; cause_pc = 0; cause_trig = 0; FSM = IDLE.
- CSR writes take effect at the next clock edge and target the trigger indexed by the current tselect.
  - tselect write: take wr_data[0] only if wr_data[31:1] == 0; otherwise keep the old value.
  - tdata1/2/3 writes to a trigger whose dmode = 1 are ignored unless dbg_mode = 1.
  - dmode is writable only when dbg_mode = 1; otherwise the written dmode is forced to 0.
- FSM states:
  - IDLE: if dbg_mode = 0 and (trig0_hit or trig1_hit), accept the hit. Trigger 0 has priority. Capture hit_pc and the trigger index, and set that trigger's tdata1.hit.
    - If action = 1 and dmode = 1: go to HALT_WAIT and set halt_req = 1.
    - Otherwise (action = 0, or action = 1 with dmode = 0): go to EXP_WAIT and set bkpt_exp_req = 1.
    - Latency: request high exactly 1 cycle after the hit cycle.
  - HALT_WAIT: hold halt_req and cause_* stable. On halt_ack, go to COOLDOWN; halt_req drops the next cycle.
  - EXP_WAIT: same as HALT_WAIT, using bkpt_exp_req / bkpt_exp_ack.
  - COOLDOWN: one cycle with all hits ignored, then go to IDLE. This prevents re-firing on the same retiring PC.
- Hits are ignored:
  - in any state other than IDLE (dropped, not queued);
  - in IDLE while dbg_mode = 1.
- halt_req and bkpt_exp_req are never high together.
- A request asserted in the same cycle as its ack (ack early) is not possible: ack is sampled only in the WAIT states.
- A tdata1 CSR write in the same cycle as a hit on the same trigger: the written value applies, except hit is forced to 1.
- hit is cleared only by a CSR write of 0.
- cpu_rst asserted in any state returns all registers to their reset values at the next edge; pending requests drop.

Decomposition:
- A shared debug package holds:
  - CSR addresses;
  - tdata1 field bit positions, and TYPE_MCONTROL = 2;
  - ACTION_EXP = 0 and ACTION_DBG = 1;
  - the tdata1 writable-bit mask, and the reset value 32'h2000_0000;
  - FSM state encodings.
- One sub-module, trig_csr_bank, holds the CSR storage, write masking, dmode protection and read mux.
- The FSM, arbitration and cause capture live in trig_ctrl.

Test Plan:
- Reset/readback: cpu_rst = 1 for 2 cycles, then read 0x7A1 -> 32'h2000_0000; read 0x7A0 -> 0; both req = 0.
- Exception path: tdata1_t0 action = 0, dbg_mode = 0; pulse trig0_hit with hit_pc = 32'h0000_1234.
  - Next cycle: bkpt_exp_req = 1, cause_pc = 32'h0000_1234, cause_trig = 0, tdata1_t0[20] = 1.
  - bkpt_exp_req is held 5 cycles until bkpt_exp_ack, drops 1 cycle after the ack, and a hit during COOLDOWN is ignored.
- Debug path: write tdata1 with dmode = 1, action = 1 while dbg_mode = 1. Then, with dbg_mode = 0, pulse trig1_hit with tselect = 1 -> halt_req = 1; halt_ack -> halt_req = 0 next cycle.
- Protection: with dmode = 1 and dbg_mode = 0, write tdata2 = 32'hDEAD_BEEF -> readback is unchanged. Write tselect = 5 -> tselect stays at its old value.
- Arbitration: trig0_hit and trig1_hit in the same cycle -> cause_trig = 0, only tdata1_t0.hit set; a trig1_hit during EXP_WAIT is dropped.
- Reset mid-op: assert cpu_rst while in HALT_WAIT -> next cycle halt_req = 0, tdata1_t0 = 32'h2000_0000, FSM accepts a new hit immediately after reset.

Source files
------------

// File: rtl/trig_ctrl_pkg.sv
// Shared debug-trigger definitions: CSR addresses, tdata1 field layout,
// action codes and the trigger sequencer state encoding.
package trig_ctrl_pkg;

  localparam logic [11:0] CSR_TSELECT_ADDR = 12'h7A0;
  localparam logic [11:0] CSR_TDATA1_ADDR  = 12'h7A1;

  localparam int TD1_TYPE_LSB   = 28;
  localparam int TD1_DMODE      = 27;
  localparam int TD1_HIT        = 20;
  localparam int TD1_ACTION_LSB = 12;
  localparam int TD1_ACTION_MSB = 15;

  localparam logic [3:0] TYPE_MCONTROL = 4'd2;
  localparam logic [3:0] ACTION_EXP    = 4'd0;
  localparam logic [3:0] ACTION_DBG    = 4'd1;

  // dmode, hit, timing, sizelo, action, chain, match, m, execute, store, load
  localparam logic [31:0] TDATA1_WMASK = 32'h0817_FFC7;
  localparam logic [31:0] TDATA1_RESET = {TYPE_MCONTROL, 28'h0};

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HALT_WAIT = 2'd1,
    ST_EXP_WAIT  = 2'd2,
    ST_COOLDOWN  = 2'd3
  } trig_state_e;

  // Applies read-only fields and drops dmode when written from outside debug mode.
  function automatic logic [31:0] tdata1_sanitize(input logic [31:0] wr_data,
                                                  input logic        dbg_mode);
    logic [31:0] v;
    v = (wr_data & TDATA1_WMASK) | TDATA1_RESET;
    if (!dbg_mode) v[TD1_DMODE] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/trig_csr_bank.sv
// Trigger CSR storage (tselect, tdata1/2/3 x2) with write masking,
// dmode write protection, hit-bit set port and combinational read mux.
module trig_csr_bank
  import trig_ctrl_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter logic [11:0] CSR_TSELECT = CSR_TSELECT_ADDR,
  parameter logic [11:0] CSR_TDATA1  = CSR_TDATA1_ADDR
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  input  logic [11:0]           csr_addr,
  input  logic                  csr_wr_en,
  input  logic [DATA_WIDTH-1:0] csr_wr_data,
  input  logic                  dbg_mode,
  input  logic [1:0]            i_set_hit,
  output logic [DATA_WIDTH-1:0] csr_rd_data,
  output logic                  tselect,
  output logic [DATA_WIDTH-1:0] tdata1_t0,
  output logic [DATA_WIDTH-1:0] tdata1_t1,
  output logic [DATA_WIDTH-1:0] tdata2_t0,
  output logic [DATA_WIDTH-1:0] tdata2_t1,
  output logic [DATA_WIDTH-1:0] tdata3_t0,
  output logic [DATA_WIDTH-1:0] tdata3_t1
);

  localparam logic [11:0] CSR_TDATA2 = CSR_TDATA1 + 12'd1;
  localparam logic [11:0] CSR_TDATA3 = CSR_TDATA1 + 12'd2;
  localparam logic [DATA_WIDTH-1:0] TD1_RST = DATA_WIDTH'(TDATA1_RESET);

  logic                  r_tselect;
  logic [DATA_WIDTH-1:0] r_tdata1 [2];
  logic [DATA_WIDTH-1:0] r_tdata2 [2];
  logic [DATA_WIDTH-1:0] r_tdata3 [2];
  logic [DATA_WIDTH-1:0] w_tdata1_nxt [2];
  logic [DATA_WIDTH-1:0] w_tdata2_nxt [2];
  logic [DATA_WIDTH-1:0] w_tdata3_nxt [2];
  logic [DATA_WIDTH-1:0] w_td1_wval;
  logic                  w_td_wr_ok;
  logic                  w_tsel_wr;

  assign w_td1_wval = DATA_WIDTH'(tdata1_sanitize(32'(csr_wr_data), dbg_mode));
  // A trigger owned by the debugger (dmode=1) is frozen outside debug mode.
  assign w_td_wr_ok = csr_wr_en && !(r_tdata1[r_tselect][TD1_DMODE] && !dbg_mode);
  assign w_tsel_wr  = csr_wr_en && (csr_addr == CSR_TSELECT) &&
                      (csr_wr_data[DATA_WIDTH-1:1] == '0);

  always_comb begin
    for (int t = 0; t < 2; t++) begin
      w_tdata1_nxt[t] = r_tdata1[t];
      w_tdata2_nxt[t] = r_tdata2[t];
      w_tdata3_nxt[t] = r_tdata3[t];
      if (w_td_wr_ok && (r_tselect == 1'(t))) begin
        if (csr_addr == CSR_TDATA1) w_tdata1_nxt[t] = w_td1_wval;
        if (csr_addr == CSR_TDATA2) w_tdata2_nxt[t] = csr_wr_data;
        if (csr_addr == CSR_TDATA3) w_tdata3_nxt[t] = csr_wr_data;
      end
      // A same-cycle hit wins over a written hit=0.
      if (i_set_hit[t]) w_tdata1_nxt[t][TD1_HIT] = 1'b1;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_tselect <= 1'b0;
      for (int t = 0; t < 2; t++) begin
        r_tdata1[t] <= TD1_RST;
        r_tdata2[t] <= '0;
        r_tdata3[t] <= '0;
      end
    end else begin
      if (w_tsel_wr) r_tselect <= csr_wr_data[0];
      for (int t = 0; t < 2; t++) begin
        r_tdata1[t] <= w_tdata1_nxt[t];
        r_tdata2[t] <= w_tdata2_nxt[t];
        r_tdata3[t] <= w_tdata3_nxt[t];
      end
    end
  end

  always_comb begin
    csr_rd_data = '0;
    if (csr_addr == CSR_TSELECT)     csr_rd_data = DATA_WIDTH'(r_tselect);
    else if (csr_addr == CSR_TDATA1) csr_rd_data = r_tdata1[r_tselect];
    else if (csr_addr == CSR_TDATA2) csr_rd_data = r_tdata2[r_tselect];
    else if (csr_addr == CSR_TDATA3) csr_rd_data = r_tdata3[r_tselect];
  end

  assign tselect   = r_tselect;
  assign tdata1_t0 = r_tdata1[0];
  assign tdata1_t1 = r_tdata1[1];
  assign tdata2_t0 = r_tdata2[0];
  assign tdata2_t1 = r_tdata2[1];
  assign tdata3_t0 = r_tdata3[0];
  assign tdata3_t1 = r_tdata3[1];

endmodule

// File: rtl/trig_ctrl.sv
// Debug trigger controller: arbitrates matcher hits, raises a halt or
// breakpoint-exception request, captures the cause and waits for the ack.
module trig_ctrl
  import trig_ctrl_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter int          ADDR_WIDTH  = 32,
  parameter logic [11:0] CSR_TSELECT = CSR_TSELECT_ADDR,
  parameter logic [11:0] CSR_TDATA1  = CSR_TDATA1_ADDR
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  input  logic [11:0]           csr_addr,
  input  logic                  csr_wr_en,
  input  logic [DATA_WIDTH-1:0] csr_wr_data,
  output logic [DATA_WIDTH-1:0] csr_rd_data,
  input  logic                  dbg_mode,
  input  logic                  trig0_hit,
  input  logic                  trig1_hit,
  input  logic [ADDR_WIDTH-1:0] hit_pc,
  output logic                  tselect,
  output logic [DATA_WIDTH-1:0] tdata1_t0,
  output logic [DATA_WIDTH-1:0] tdata1_t1,
  output logic [DATA_WIDTH-1:0] tdata2_t0,
  output logic [DATA_WIDTH-1:0] tdata2_t1,
  output logic [DATA_WIDTH-1:0] tdata3_t0,
  output logic [DATA_WIDTH-1:0] tdata3_t1,
  output logic                  halt_req,
  input  logic                  halt_ack,
  output logic                  bkpt_exp_req,
  input  logic                  bkpt_exp_ack,
  output logic [ADDR_WIDTH-1:0] cause_pc,
  output logic                  cause_trig,
  output logic [1:0]            o_dbg_state
);

  // Handshake: a request rises the cycle after an accepted hit and stays high
  // with cause_* stable until its ack is sampled high in the matching WAIT
  // state; it then falls on the next edge. Acks in any other state are ignored.

  trig_state_e           r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cause_pc;
  logic                  r_cause_trig;
  logic                  w_accept;
  logic                  w_pick;
  logic                  w_sel_dmode;
  logic [3:0]            w_sel_action;
  logic [1:0]            w_set_hit;

  trig_csr_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .CSR_TSELECT(CSR_TSELECT),
    .CSR_TDATA1 (CSR_TDATA1)
  ) u_csr_bank (
    .cpu_clk    (cpu_clk),
    .cpu_rst    (cpu_rst),
    .csr_addr   (csr_addr),
    .csr_wr_en  (csr_wr_en),
    .csr_wr_data(csr_wr_data),
    .dbg_mode   (dbg_mode),
    .i_set_hit  (w_set_hit),
    .csr_rd_data(csr_rd_data),
    .tselect    (tselect),
    .tdata1_t0  (tdata1_t0),
    .tdata1_t1  (tdata1_t1),
    .tdata2_t0  (tdata2_t0),
    .tdata2_t1  (tdata2_t1),
    .tdata3_t0  (tdata3_t0),
    .tdata3_t1  (tdata3_t1)
  );

  // Trigger 0 has priority; trigger 1 is chosen only when 0 is quiet.
  assign w_pick       = !trig0_hit;
  assign w_sel_dmode  = w_pick ? tdata1_t1[TD1_DMODE] : tdata1_t0[TD1_DMODE];
  assign w_sel_action = w_pick ? tdata1_t1[TD1_ACTION_MSB:TD1_ACTION_LSB]
                               : tdata1_t0[TD1_ACTION_MSB:TD1_ACTION_LSB];

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_set_hit   = 2'b00;
    case (r_state)
      ST_IDLE: begin
        if (!dbg_mode && (trig0_hit || trig1_hit)) begin
          w_accept          = 1'b1;
          w_set_hit[w_pick] = 1'b1;
          if ((w_sel_action == ACTION_DBG) && w_sel_dmode) w_state_nxt = ST_HALT_WAIT;
          else                                             w_state_nxt = ST_EXP_WAIT;
        end
      end
      ST_HALT_WAIT: if (halt_ack)     w_state_nxt = ST_COOLDOWN;
      ST_EXP_WAIT:  if (bkpt_exp_ack) w_state_nxt = ST_COOLDOWN;
      ST_COOLDOWN:  w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_state      <= ST_IDLE;
      r_cause_pc   <= '0;
      r_cause_trig <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cause_pc   <= hit_pc;
        r_cause_trig <= w_pick;
      end
    end
  end

  assign halt_req     = (r_state == ST_HALT_WAIT);
  assign bkpt_exp_req = (r_state == ST_EXP_WAIT);
  assign cause_pc     = r_cause_pc;
  assign cause_trig   = r_cause_trig;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_trig_ctrl.sv
// Self-checking bench for trig_ctrl: CSR behaviour, both request paths,
// arbitration, drop rules and reset in flight.
module tb_trig_ctrl;
  import trig_ctrl_pkg::*;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic [11:0] csr_addr;
  logic        csr_wr_en;
  logic [31:0] csr_wr_data;
  logic [31:0] csr_rd_data;
  logic        dbg_mode;
  logic        trig0_hit, trig1_hit;
  logic [31:0] hit_pc;
  logic        tselect;
  logic [31:0] tdata1_t0, tdata1_t1, tdata2_t0, tdata2_t1, tdata3_t0, tdata3_t1;
  logic        halt_req, halt_ack, bkpt_exp_req, bkpt_exp_ack;
  logic [31:0] cause_pc;
  logic        cause_trig;
  logic [1:0]  o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] exp_q[$];  // {is_halt, trig, pc}

  trig_ctrl dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .csr_addr(csr_addr), .csr_wr_en(csr_wr_en),
    .csr_wr_data(csr_wr_data), .csr_rd_data(csr_rd_data), .dbg_mode(dbg_mode),
    .trig0_hit(trig0_hit), .trig1_hit(trig1_hit), .hit_pc(hit_pc), .tselect(tselect),
    .tdata1_t0(tdata1_t0), .tdata1_t1(tdata1_t1), .tdata2_t0(tdata2_t0),
    .tdata2_t1(tdata2_t1), .tdata3_t0(tdata3_t0), .tdata3_t1(tdata3_t1),
    .halt_req(halt_req), .halt_ack(halt_ack), .bkpt_exp_req(bkpt_exp_req),
    .bkpt_exp_ack(bkpt_exp_ack), .cause_pc(cause_pc), .cause_trig(cause_trig),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // driver tasks: inputs change and outputs are sampled at the negedge
  task automatic tick();
    @(posedge cpu_clk);
    @(negedge cpu_clk);
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csr_addr = addr; csr_wr_data = data; csr_wr_en = 1'b1;
    tick();
    csr_wr_en = 1'b0;
  endtask

  task automatic csr_read(input logic [11:0] addr, output logic [31:0] data);
    csr_addr = addr;
    #1;
    data = csr_rd_data;
  endtask

  task automatic pulse_hit(input logic t0, input logic t1, input logic [31:0] pc,
                           input logic expect_accept, input logic expect_halt);
    trig0_hit = t0; trig1_hit = t1; hit_pc = pc;
    if (expect_accept) exp_q.push_back({expect_halt, ~t0, pc});
    tick();
    trig0_hit = 1'b0; trig1_hit = 1'b0;
  endtask

  task automatic ack_req(input logic is_halt);
    if (is_halt) halt_ack = 1'b1; else bkpt_exp_ack = 1'b1;
    tick();
    halt_ack = 1'b0; bkpt_exp_ack = 1'b0;
  endtask

  // scoreboard
  task automatic pop_and_check(input string name);
    logic [33:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: request observed with empty expected queue", name);
    end else begin
      e = exp_q.pop_front();
      if ({halt_req, bkpt_exp_req, cause_trig, cause_pc} !== {e[33], ~e[33], e[32], e[31:0]}) begin
        n_fail++;
        $display("FAIL %s: halt=%b exp_req=%b trig=%b pc=%h, expected halt=%b exp_req=%b trig=%b pc=%h",
                 name, halt_req, bkpt_exp_req, cause_trig, cause_pc, e[33], ~e[33], e[32], e[31:0]);
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    cpu_rst = 1'b1;
    tick(); tick();
    cpu_rst = 1'b0;
    csr_read(12'h7A1, rd);
    n_checks++; if (rd !== 32'h2000_0000) begin n_fail++; $display("FAIL reset_tdata1: got %h expected %h", rd, 32'h2000_0000); end
    csr_read(12'h7A0, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_tselect: got %h expected 0", rd); end
    csr_read(12'h123, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL read_unmapped: got %h expected 0", rd); end
    n_checks++; if ({halt_req, bkpt_exp_req} !== 2'b00) begin n_fail++; $display("FAIL reset_reqs: got %b expected 00", {halt_req, bkpt_exp_req}); end
    n_checks++; if ({cause_trig, cause_pc, o_dbg_state} !== {1'b0, 32'h0, ST_IDLE}) begin n_fail++; $display("FAIL reset_cause_state: got %b/%h/%0d expected 0/0/0", cause_trig, cause_pc, o_dbg_state); end
  endtask

  task automatic test_exp_path();
    logic [31:0] rd;
    csr_write(12'h7A1, 32'h0000_0044);
    csr_read(12'h7A1, rd);
    n_checks++; if (rd !== 32'h2000_0044) begin n_fail++; $display("FAIL exp_cfg_readback: got %h expected %h", rd, 32'h2000_0044); end
    pulse_hit(1'b1, 1'b0, 32'h0000_1234, 1'b1, 1'b0);
    pop_and_check("exp_first_req");
    n_checks++; if (tdata1_t0[20] !== 1'b1) begin n_fail++; $display("FAIL exp_hit_bit: got %b expected 1", tdata1_t0[20]); end
    for (int i = 1; i < 5; i++) begin
      tick();
      n_checks++; if ({bkpt_exp_req, halt_req, cause_pc} !== {2'b10, 32'h0000_1234}) begin n_fail++; $display("FAIL exp_hold_%0d: req=%b halt=%b pc=%h expected 1/0/00001234", i, bkpt_exp_req, halt_req, cause_pc); end
    end
    ack_req(1'b0);
    n_checks++; if ({bkpt_exp_req, o_dbg_state} !== {1'b0, ST_COOLDOWN}) begin n_fail++; $display("FAIL exp_drop_after_ack: req=%b state=%0d expected 0/3", bkpt_exp_req, o_dbg_state); end
    pulse_hit(1'b1, 1'b0, 32'h0000_5555, 1'b0, 1'b0);
    n_checks++; if ({halt_req, bkpt_exp_req, o_dbg_state} !== {2'b00, ST_IDLE}) begin n_fail++; $display("FAIL cooldown_hit_ignored: halt=%b req=%b state=%0d expected 0/0/0", halt_req, bkpt_exp_req, o_dbg_state); end
    csr_write(12'h7A1, 32'h0000_0004);
    csr_read(12'h7A1, rd);
    n_checks++; if (rd !== 32'h2000_0004) begin n_fail++; $display("FAIL hit_clear_by_write: got %h expected %h", rd, 32'h2000_0004); end
  endtask

  task automatic test_dbg_path();
    logic [31:0] rd;
    dbg_mode = 1'b1;
    csr_write(12'h7A0, 32'h1);
    csr_write(12'h7A1, 32'h0800_1004);
    csr_read(12'h7A1, rd);
    n_checks++; if (rd !== 32'h2800_1004) begin n_fail++; $display("FAIL dbg_cfg_readback: got %h expected %h", rd, 32'h2800_1004); end
    pulse_hit(1'b0, 1'b1, 32'h0000_0F00, 1'b0, 1'b0);
    n_checks++; if ({halt_req, bkpt_exp_req, tdata1_t1[20]} !== 3'b000) begin n_fail++; $display("FAIL hit_in_dbg_mode_ignored: halt=%b req=%b hit=%b expected 000", halt_req, bkpt_exp_req, tdata1_t1[20]); end
    dbg_mode = 1'b0;
    pulse_hit(1'b0, 1'b1, 32'h8000_0010, 1'b1, 1'b1);
    pop_and_check("dbg_halt_req");
    n_checks++; if (tdata1_t1 !== 32'h2810_1004) begin n_fail++; $display("FAIL dbg_hit_bit: got %h expected %h", tdata1_t1, 32'h2810_1004); end
    tick();
    n_checks++; if (halt_req !== 1'b1) begin n_fail++; $display("FAIL dbg_halt_hold: got %b expected 1", halt_req); end
    ack_req(1'b1);
    n_checks++; if ({halt_req, bkpt_exp_req} !== 2'b00) begin n_fail++; $display("FAIL dbg_halt_drop: got %b expected 00", {halt_req, bkpt_exp_req}); end
    tick();
  endtask

  task automatic test_protection();
    logic [31:0] rd;
    csr_write(12'h7A2, 32'hDEAD_BEEF);
    csr_read(12'h7A2, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL locked_tdata2: got %h expected 0", rd); end
    csr_write(12'h7A1, 32'h0);
    csr_read(12'h7A1, rd);
    n_checks++; if (rd !== 32'h2810_1004) begin n_fail++; $display("FAIL locked_tdata1: got %h expected %h", rd, 32'h2810_1004); end
    csr_write(12'h7A0, 32'h5);
    csr_read(12'h7A0, rd);
    n_checks++; if (rd !== 32'h1 || tselect !== 1'b1) begin n_fail++; $display("FAIL tselect_bad_write: got %h expected 1", rd); end
    csr_write(12'h7A0, 32'h0);
    csr_write(12'h7A1, 32'hFFFF_FFFF);
    csr_read(12'h7A1, rd);
    n_checks++; if (rd !== 32'h2017_FFC7) begin n_fail++; $display("FAIL tdata1_ro_and_dmode: got %h expected %h", rd, 32'h2017_FFC7); end
    csr_write(12'h7A1, 32'h0000_0004);
    csr_write(12'h7A2, 32'hDEAD_BEEF);
    csr_write(12'h7A3, 32'h0000_1357);
    csr_read(12'h7A2, rd);
    n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL tdata2_write: got %h expected deadbeef", rd); end
    n_checks++; if ({tdata3_t0, tdata1_t0} !== {32'h0000_1357, 32'h2000_0004}) begin n_fail++; $display("FAIL tdata3_t0_tdata1_t0: got %h/%h expected 00001357/20000004", tdata3_t0, tdata1_t0); end
  endtask

  task automatic test_arbitration();
    dbg_mode = 1'b1;
    csr_write(12'h7A0, 32'h1);
    csr_write(12'h7A1, 32'h0800_1004);
    dbg_mode = 1'b0;
    csr_write(12'h7A0, 32'h0);
    n_checks++; if (tdata1_t1 !== 32'h2800_1004) begin n_fail++; $display("FAIL arb_t1_cleared: got %h expected %h", tdata1_t1, 32'h2800_1004); end
    pulse_hit(1'b1, 1'b1, 32'h0000_00A0, 1'b1, 1'b0);
    pop_and_check("arb_both_hits");
    n_checks++; if ({tdata1_t0[20], tdata1_t1[20]} !== 2'b10) begin n_fail++; $display("FAIL arb_hit_bits: got %b expected 10", {tdata1_t0[20], tdata1_t1[20]}); end
    pulse_hit(1'b0, 1'b1, 32'h0000_00B0, 1'b0, 1'b0);
    n_checks++; if ({bkpt_exp_req, cause_trig, cause_pc, tdata1_t1[20]} !== {1'b1, 1'b0, 32'h0000_00A0, 1'b0}) begin n_fail++; $display("FAIL arb_drop_in_wait: req=%b trig=%b pc=%h hit1=%b expected 1/0/000000a0/0", bkpt_exp_req, cause_trig, cause_pc, tdata1_t1[20]); end
    ack_req(1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    csr_addr = 12'h7A1; csr_wr_data = 32'h0000_0005; csr_wr_en = 1'b1;
    pulse_hit(1'b1, 1'b0, 32'h0000_00C0, 1'b1, 1'b0);
    csr_wr_en = 1'b0;
    pop_and_check("write_hit_collision_req");
    n_checks++; if (tdata1_t0 !== 32'h2010_0005) begin n_fail++; $display("FAIL write_hit_collision: got %h expected %h", tdata1_t0, 32'h2010_0005); end
    ack_req(1'b0);
    tick();
    pulse_hit(1'b0, 1'b1, 32'h0000_00D0, 1'b1, 1'b1);
    pop_and_check("b2b_halt_req");
  endtask

  task automatic test_reset_midop();
    cpu_rst = 1'b1;
    tick();
    cpu_rst = 1'b0;
    n_checks++; if ({halt_req, bkpt_exp_req, o_dbg_state} !== {2'b00, ST_IDLE}) begin n_fail++; $display("FAIL midop_reset_reqs: halt=%b req=%b state=%0d expected 0/0/0", halt_req, bkpt_exp_req, o_dbg_state); end
    n_checks++; if ({tdata1_t0, tdata1_t1, tdata2_t0, cause_pc} !== {32'h2000_0000, 32'h2000_0000, 32'h0, 32'h0}) begin n_fail++; $display("FAIL midop_reset_regs: t0=%h t1=%h d2=%h pc=%h", tdata1_t0, tdata1_t1, tdata2_t0, cause_pc); end
    pulse_hit(1'b1, 1'b0, 32'h0000_4444, 1'b1, 1'b0);
    pop_and_check("post_reset_hit");
    ack_req(1'b0);
    tick();
  endtask

  initial begin
    cpu_rst = 1'b1; csr_addr = '0; csr_wr_en = 1'b0; csr_wr_data = '0; dbg_mode = 1'b0;
    trig0_hit = 1'b0; trig1_hit = 1'b0; hit_pc = '0; halt_ack = 1'b0; bkpt_exp_ack = 1'b0;
    test_reset();
    test_exp_path();
    test_dbg_path();
    test_protection();
    test_arbitration();
    test_back_to_back();
    test_reset_midop();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
